regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 1, making register 0 hard-wired zero when 1.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 ra_a  in  ADDR_W  read address, port A.
REQ-007 ra_b  in  ADDR_W  read address, port B.
REQ-008 rd_a  out  DATA_W  read data, port A, combinational.
REQ-009 rd_b  out  DATA_W  read data, port B, combinational.
REQ-010 we  in  1  write enable.
REQ-011 wa  in  ADDR_W  write address.
REQ-012 wd  in  DATA_W  write data.
REQ-013 pset  in  1  mark register pset_addr pending (result outstanding).
REQ-014 pset_addr  in  ADDR_W  register to mark pending.
REQ-015 pend_a  out  1  pending bit of ra_a.
REQ-016 pend_b  out  1  pending bit of ra_b.
REQ-017 ready  out  1  high when initialisation complete and writes accepted.

Function
REQ-018 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-019 In CLEAR, a counter clr_cnt SHALL write zero to register clr_cnt each cycle and increment by 1.
REQ-020 CLEAR SHALL transition to RUN on the edge where clr_cnt == DEPTH-1 is written; CLEAR lasts exactly DEPTH cycles.
REQ-021 ready SHALL be 0 in CLEAR and 1 in RUN, registered (no combinational path from inputs).
REQ-022 In CLEAR, we and pset SHALL be ignored, rd_a/rd_b SHALL read 0 and pend_a/pend_b SHALL read 0.
REQ-023 In RUN, when we=1, reg[wa] SHALL take wd at the rising edge and pending[wa] SHALL clear.
REQ-024 In RUN, when pset=1, pending[pset_addr] SHALL set at the rising edge.
REQ-025 Simultaneous we and pset to the same address SHALL leave pending set (pset wins) and still write wd.
REQ-026 With ZERO_REG=1, writes and pset to address 0 SHALL be ignored and reads of address 0 SHALL return 0 with pend 0.
REQ-027 Read port SHALL bypass: if we=1, in RUN, wa == ra_x and the write is not suppressed by REQ-026, rd_x SHALL equal wd in the same cycle.
REQ-028 pend_x SHALL bypass likewise: same-cycle write to ra_x forces pend_x=0 unless pset to the same address is also active.
REQ-029 Otherwise rd_x SHALL equal reg[ra_x] and pend_x SHALL equal pending[ra_x].
REQ-030 Both read ports SHALL be fully independent; ra_a == ra_b SHALL return identical data.
REQ-031 All address arithmetic SHALL be ADDR_W bits; clr_cnt SHALL not wrap past DEPTH-1 in RUN (held or unused).

Reset
REQ-032 Asserting rst SHALL immediately force state CLEAR, clr_cnt 0, ready 0, all pending bits 0.
REQ-033 Register contents need not reset directly; the CLEAR sweep zeroes them after rst deasserts.
REQ-034 rst asserted mid-CLEAR or mid-RUN SHALL restart the full DEPTH-cycle sweep from address 0.
REQ-035 After rst deasserts, ready SHALL rise on the DEPTH-th rising edge (32 with defaults).

Verification
REQ-036 Reset release, defaults -> ready 0 for 31 edges, 1 after edge 32; all 32 registers read 0.
REQ-037 RUN, we=1 wa=5 wd=0xDEADBEEF, ra_a=5 same cycle -> rd_a=0xDEADBEEF combinationally; next cycle (we=0) rd_a=0xDEADBEEF.
REQ-038 RUN, we=1 wa=0 wd=0x12345678, pset=1 pset_addr=0 -> rd_a(ra_a=0)=0, pend_a=0 both during and after.
REQ-039 pset addr 7 -> pend_b(ra_b=7)=1; later we wa=7 -> pend_b=0 same cycle; simultaneous we+pset on 7 -> pend_b=1 after edge.
REQ-040 Assert rst at sweep cycle 10 and again in RUN after writing reg 3=0xA5 -> pending cleared immediately, ready 0, full 32-cycle sweep, reg 3 reads 0 after.
REQ-041 Parameter sweep DATA_W=16, ADDR_W=3, ZERO_REG=0 -> ready after 8 edges, write 0xBEEF to reg 0 reads back 0xBEEF.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: two read ports with pending status, one write
// port, one pending-set port and the ready flag.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra_a;
  logic [ADDR_W-1:0] ra_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              pset;
  logic [ADDR_W-1:0] pset_addr;
  logic              pend_a;
  logic              pend_b;
  logic              ready;

  modport master (
    output ra_a, ra_b, we, wa, wd, pset, pset_addr,
    input  rd_a, rd_b, pend_a, pend_b, ready
  );

  modport slave (
    input  ra_a, ra_b, we, wa, wd, pset, pset_addr,
    output rd_a, rd_b, pend_a, pend_b, ready
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with per-register pending bits, write
// bypass on the read ports and a post-reset zeroing sweep.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic              run;
  logic              wr_ok;
  logic              pset_ok;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [DATA_W-1:0] rd_sel(
    input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] stored,
    input logic r, input logic w, input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd);
    if (!r || is_zero(ra)) return '0;
    if (w && (wa == ra))   return wd;
    return stored;
  endfunction

  // A same-cycle write clears the pending bit unless a pset hits the same register.
  function automatic logic pend_sel(
    input logic [ADDR_W-1:0] ra, input logic stored,
    input logic r, input logic w, input logic [ADDR_W-1:0] wa,
    input logic p, input logic [ADDR_W-1:0] pa);
    if (!r || is_zero(ra)) return 1'b0;
    if (w && (wa == ra))   return p && (pa == ra);
    return stored;
  endfunction

  assign run     = (state == RUN);
  assign wr_ok   = run && bus.we   && !is_zero(bus.wa);
  assign pset_ok = run && bus.pset && !is_zero(bus.pset_addr);

  assign bus.ready  = run;
  assign bus.rd_a   = rd_sel(bus.ra_a, mem[bus.ra_a], run, wr_ok, bus.wa, bus.wd);
  assign bus.rd_b   = rd_sel(bus.ra_b, mem[bus.ra_b], run, wr_ok, bus.wa, bus.wd);
  assign bus.pend_a = pend_sel(bus.ra_a, pending[bus.ra_a], run, wr_ok, bus.wa,
                               pset_ok, bus.pset_addr);
  assign bus.pend_b = pend_sel(bus.ra_b, pending[bus.ra_b], run, wr_ok, bus.wa,
                               pset_ok, bus.pset_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // The sweep counter parks on the last address once RUN is reached.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      CLEAR: begin
        if (clr_cnt == LAST) begin
          state_nxt = RUN;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      if (wr_ok)   pending[bus.wa]        <= 1'b0;
      if (pset_ok) pending[bus.pset_addr] <= 1'b1;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes it.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[bus.wa] <= bus.wd;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp with an array-based reference model; a
// second small instance covers the narrow, no-zero-register configuration.
module tb_regfile_mp;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_mp_if #(.DATA_W(16), .ADDR_W(3)) bus2 ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register contents, pending flags, edges since reset.
  logic [31:0] m_reg  [32];
  bit          m_pend [32];
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit rdy,
    input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (!rdy || ra == 0) return 32'h0;
    if (w && wa == ra && wa != 0) return wd;
    return m_reg[ra];
  endfunction

  function automatic logic exp_pend(input logic [4:0] ra, input bit rdy,
    input logic w, input logic [4:0] wa, input logic p, input logic [4:0] pa);
    if (!rdy || ra == 0) return 1'b0;
    if (w && wa == ra) return p && pa == ra;
    return m_pend[ra];
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    m_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 32'h0;
      m_pend[i] = 1'b0;
    end
    #1;
    chk("rst_ready", bus.ready, 1'b0);
    chk("rst_ready2", bus2.ready, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input logic [4:0] a, input logic [4:0] b, input logic w,
    input logic [4:0] wa_i, input logic [31:0] wd_i, input logic p, input logic [4:0] pa);
    bit rdy;
    bus.ra_a = a;  bus.ra_b = b;
    bus.we = w;    bus.wa = wa_i;  bus.wd = wd_i;
    bus.pset = p;  bus.pset_addr = pa;
    #2;
    rdy = (m_cnt >= 32);
    chk("ready",  bus.ready,  rdy);
    chk("ready2", bus2.ready, m_cnt >= 8);
    chk("rd_a",   bus.rd_a,   exp_rd(a, rdy, w, wa_i, wd_i));
    chk("rd_b",   bus.rd_b,   exp_rd(b, rdy, w, wa_i, wd_i));
    chk("pend_a", bus.pend_a, exp_pend(a, rdy, w, wa_i, p, pa));
    chk("pend_b", bus.pend_b, exp_pend(b, rdy, w, wa_i, p, pa));
    @(posedge clk);
    if (rdy) begin
      if (w && wa_i != 0) begin
        m_reg[wa_i]  = wd_i;
        m_pend[wa_i] = 1'b0;
      end
      if (p && pa != 0) m_pend[pa] = 1'b1;
    end
    if (m_cnt < 32) m_cnt++;
    #1;
  endtask

  task automatic rand_step(input int amax);
    step(5'($urandom_range(0, amax)), 5'($urandom_range(0, amax)),
         1'($urandom), 5'($urandom_range(0, amax)), $urandom,
         1'($urandom), 5'($urandom_range(0, amax)));
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.ra_a = '0; bus.ra_b = '0; bus.we = 1'b0; bus.wa = '0; bus.wd = '0;
    bus.pset = 1'b0; bus.pset_addr = '0;
    bus2.ra_a = '0; bus2.ra_b = '0; bus2.we = 1'b0; bus2.wa = '0; bus2.wd = '0;
    bus2.pset = 1'b0; bus2.pset_addr = '0;
    #1;

    // Initial sweep with random traffic that must be ignored.
    apply_reset();
    for (int i = 0; i < 33; i++) rand_step(31);
    for (int i = 0; i < 32; i++) step(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Write with same-cycle bypass, then plain read.
    step(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    step(5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("reg5_hold", bus.rd_a, 32'hDEADBEEF);

    // Register 0 ignores writes and pset.
    step(5'd0, 5'd0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    step(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Pending set / write-clear / simultaneous set wins.
    step(5'd1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    step(5'd1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    step(5'd1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    step(5'd7, 5'd7, 1'b1, 5'd7, 32'h78, 1'b1, 5'd7);
    step(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    // Random traffic, narrow address range first to force collisions.
    for (int i = 0; i < 200; i++) rand_step(3);
    for (int i = 0; i < 200; i++) rand_step(31);

    // Reset partway through the sweep, then again from RUN.
    apply_reset();
    for (int i = 0; i < 10; i++) rand_step(31);
    apply_reset();
    for (int i = 0; i < 33; i++) rand_step(31);
    step(5'd3, 5'd9, 1'b1, 5'd3, 32'hA5, 1'b1, 5'd9);
    step(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    apply_reset();
    for (int i = 0; i < 33; i++) step(5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    chk("reg3_cleared", bus.rd_a, 32'h0);
    chk("pend9_cleared", bus.pend_b, 1'b0);

    // Narrow instance: register 0 is an ordinary register.
    bus2.we = 1'b1; bus2.wa = 3'd0; bus2.wd = 16'hBEEF; bus2.ra_a = 3'd0; bus2.ra_b = 3'd1;
    #2;
    chk("n_bypass0", bus2.rd_a, 16'hBEEF);
    chk("n_other",   bus2.rd_b, 16'h0);
    @(posedge clk); #1;
    bus2.we = 1'b0; bus2.pset = 1'b1; bus2.pset_addr = 3'd0;
    #2;
    chk("n_read0", bus2.rd_a, 16'hBEEF);
    chk("n_pend0_pre", bus2.pend_a, 1'b0);
    @(posedge clk); #1;
    bus2.pset = 1'b0;
    #2;
    chk("n_pend0", bus2.pend_a, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
